dc_req_fifo: RTL and testbench
==============================

// Module: dc_req_fifo
// PURPOSE
//  Request queue between the DRAM-cache index extractor and the tag-check stage.
//  Buffers {rw, id, addr} entries pushed by the extractor and raises almost-full early
//  enough to absorb its 2-cycle decide-to-write pipeline.
//  Presents entries first-word-fall-through on a valid/ready port to the tag checker.
// PARAMETERS
//  ADDR_WIDTH    `AXI_ADDR_WIDTH (64)  request address width
//  ID_WIDTH      `AXI_ID_WIDTH (16)    transaction ID width
//  DEPTH         16                    entries; power of two, >= 4
//  AFULL_MARGIN  2                     afull asserts when free slots <= AFULL_MARGIN
//  (local) ENTRY_W = ADDR_WIDTH+ID_WIDTH+1; CNT_W = $clog2(DEPTH)+1
// PORTS
//  clk              in   1        clock, all logic posedge
//  rst              in   1        asynchronous, active-high reset
//  fifo_write_en_i  in   1        push strobe from index extractor
//  fifo_data_i      in   ENTRY_W  [ENTRY_W-1]=rw (0 rd, 1 wr), [ADDR+ID-1:ADDR]=id, [ADDR-1:0]=addr
//  fifo_afull_o     out  1        almost-full to index extractor
//  req_valid_o      out  1        head entry valid
//  req_data_o       out  ENTRY_W  head entry, same packing as fifo_data_i
//  req_ready_i      in   1        tag checker accepts head
//  count_o          out  CNT_W    current occupancy 0..DEPTH
//  ovf_o            out  1        sticky: a push was dropped
//  push_total_o     out  32       pushes accepted (stats; see CONFIGURATION)
//  high_water_o     out  CNT_W    maximum occupancy reached (stats)
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk release): wr_ptr=rd_ptr=0, count=0, req_valid_o=0,
//    fifo_afull_o=0, ovf_o=0, push_total_o=0, high_water_o=0. Storage array is not cleared;
//    req_data_o is don't-care while req_valid_o=0. Reset mid-operation discards all entries.
//  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0. count is a separate register.
//  - pop  = req_valid_o & req_ready_i.
//  - push = fifo_write_en_i & (count<DEPTH | pop). Full with simultaneous pop: push accepted,
//    count stays DEPTH.
//  - Push when full with no pop: entry dropped, no pointer change, ovf_o set next cycle and
//    held until rst.
//  - count_next = count + push - pop. Simultaneous push/pop leaves count unchanged.
//  - FWFT: req_valid_o = (count!=0). Push into empty FIFO gives req_valid_o=1 and the entry on
//    req_data_o one cycle later. Empty FIFO with push: no pop that cycle (valid low).
//  - req_data_o = mem[rd_ptr], combinational read of the array.
//  - req_data_o and req_valid_o hold stable while req_valid_o=1 and req_ready_i=0.
//  - fifo_afull_o = (count >= DEPTH-AFULL_MARGIN), decoded from the registered count. No
//    combinational path from fifo_write_en_i or req_ready_i.
//  - Ordering is strict FIFO. Reads and writes share one queue; no reordering or merging.
// CONFIGURATION
//  DC_REQ_FIFO_STATS_EN defined:
//    - push_total_o increments on each accepted push and saturates at 32'hFFFF_FFFF.
//    - high_water_o <= max(high_water_o, count_next) every cycle.
//  DC_REQ_FIFO_STATS_EN undefined:
//    - Both ports are still present and tied to 0; no stats registers are synthesised.
//  All other behaviour is identical in both builds.
// TESTING
//  1 rst=1 mid-traffic with count=5 -> same cycle count_o=0, req_valid_o=0, afull=0, ovf=0.
//  2 Push {1,16'h00A5,64'h1000} into empty, ready=0 -> next cycle valid=1, data matches,
//    held for 10 cycles.
//  3 DEPTH=16, AFULL_MARGIN=2: 14 pushes -> afull=1 once count_o=14; pops back to 13 -> afull=0.
//  4 Fill to 16, push with ready=0 -> entry dropped, ovf_o=1 next cycle, count_o=16, head unchanged.
//  5 Full with push+pop same cycle -> count_o stays 16, new entry exits as the 16th pop.
//  6 40 random push/pop cycles crossing the pointer wrap; STATS_EN build -> order preserved,
//    push_total_o = accepted pushes, high_water_o = scoreboard max.

Source files
------------

// File: rtl/dc_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dc_req_fifo
//  Description : Request queue between the DRAM-cache index extractor and the
//                tag-check stage. Buffers {rw, id, addr} entries and presents
//                them first-word-fall-through on a valid/ready port. Almost-full
//                is raised early enough to absorb the extractor's 2-cycle
//                decide-to-write pipeline.
//  Ports       : clk, rst            - clock, async active-high reset
//                fifo_write_en_i     - push strobe from index extractor
//                fifo_data_i         - {rw, id, addr} entry to push
//                fifo_afull_o        - almost-full to index extractor
//                req_valid_o         - head entry valid
//                req_data_o          - head entry, same packing as fifo_data_i
//                req_ready_i         - tag checker accepts head
//                count_o             - current occupancy 0..DEPTH
//                ovf_o               - sticky: a push was dropped
//                push_total_o        - accepted pushes (stats build only)
//                high_water_o        - max occupancy reached (stats build only)
//  Options     : define DC_REQ_FIFO_STATS_EN to build the statistics counters;
//                otherwise push_total_o and high_water_o are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module dc_req_fifo #(
  parameter int ADDR_WIDTH   = 64,
  parameter int ID_WIDTH     = 16,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fifo_write_en_i,
  input  logic [ADDR_WIDTH+ID_WIDTH:0]  fifo_data_i,
  output logic                          fifo_afull_o,
  output logic                          req_valid_o,
  output logic [ADDR_WIDTH+ID_WIDTH:0]  req_data_o,
  input  logic                          req_ready_i,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          ovf_o,
  output logic [31:0]                   push_total_o,
  output logic [$clog2(DEPTH):0]        high_water_o
);

  localparam int ENTRY_W = ADDR_WIDTH + ID_WIDTH + 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - AFULL_MARGIN);

  // Storage is never reset; only pointers and count define the contents.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;

  logic w_pop;
  logic w_push;
  logic w_drop;

  always_comb begin
    w_pop    = (count_q != '0) && req_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    w_push   = fifo_write_en_i && ((count_q != FULL_CNT) || w_pop);
    w_drop   = fifo_write_en_i && !w_push;

    // Pointers are log2(DEPTH) wide, so increment wraps DEPTH-1 -> 0.
    wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d  = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    ovf_d    = ovf_q | w_drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= fifo_data_i;
    end
  end

  assign req_valid_o  = (count_q != '0);
  assign req_data_o   = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign ovf_o        = ovf_q;
  // Decoded from the registered count only: no input-to-afull path.
  assign fifo_afull_o = (count_q >= AFULL_CNT);

`ifdef DC_REQ_FIFO_STATS_EN
  logic [31:0]      push_total_q, push_total_d;
  logic [CNT_W-1:0] high_water_q, high_water_d;

  always_comb begin
    push_total_d = push_total_q;
    if (w_push && (push_total_q != 32'hFFFF_FFFF)) begin
      push_total_d = push_total_q + 32'd1;
    end
    high_water_d = (count_d > high_water_q) ? count_d : high_water_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_total_q <= '0;
      high_water_q <= '0;
    end else begin
      push_total_q <= push_total_d;
      high_water_q <= high_water_d;
    end
  end

  assign push_total_o = push_total_q;
  assign high_water_o = high_water_q;
`else
  assign push_total_o = '0;
  assign high_water_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dc_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dc_req_fifo
//  Description : Self-checking bench for dc_req_fifo. A queue-based reference
//                model tracks contents, overflow and statistics; every cycle
//                the DUT outputs are compared against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dc_req_fifo;

  localparam int ADDR_WIDTH   = 64;
  localparam int ID_WIDTH     = 16;
  localparam int DEPTH        = 16;
  localparam int AFULL_MARGIN = 2;
  localparam int ENTRY_W      = ADDR_WIDTH + ID_WIDTH + 1;
  localparam int CNT_W        = $clog2(DEPTH) + 1;

  logic               clk;
  logic               rst;
  logic               fifo_write_en_i;
  logic [ENTRY_W-1:0] fifo_data_i;
  logic               fifo_afull_o;
  logic               req_valid_o;
  logic [ENTRY_W-1:0] req_data_o;
  logic               req_ready_i;
  logic [CNT_W-1:0]   count_o;
  logic               ovf_o;
  logic [31:0]        push_total_o;
  logic [CNT_W-1:0]   high_water_o;

  dc_req_fifo #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .ID_WIDTH     (ID_WIDTH),
    .DEPTH        (DEPTH),
    .AFULL_MARGIN (AFULL_MARGIN)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_write_en_i (fifo_write_en_i),
    .fifo_data_i     (fifo_data_i),
    .fifo_afull_o    (fifo_afull_o),
    .req_valid_o     (req_valid_o),
    .req_data_o      (req_data_o),
    .req_ready_i     (req_ready_i),
    .count_o         (count_o),
    .ovf_o           (ovf_o),
    .push_total_o    (push_total_o),
    .high_water_o    (high_water_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [ENTRY_W-1:0] m_q[$];
  bit                 m_ovf;
  longint unsigned    m_total;
  int                 m_hw;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_total = 0;
    m_hw    = 0;
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = m_q.size();
    chk({tag, ":count"}, 128'(count_o), 128'(sz));
    chk({tag, ":valid"}, 128'(req_valid_o), 128'(sz != 0));
    chk({tag, ":afull"}, 128'(fifo_afull_o), 128'(sz >= DEPTH - AFULL_MARGIN));
    chk({tag, ":ovf"},   128'(ovf_o), 128'(m_ovf));
    if (sz != 0) chk({tag, ":data"}, 128'(req_data_o), 128'(m_q[0]));
`ifdef DC_REQ_FIFO_STATS_EN
    chk({tag, ":push_total"}, 128'(push_total_o), 128'(m_total));
    chk({tag, ":high_water"}, 128'(high_water_o), 128'(m_hw));
`else
    chk({tag, ":push_total"}, 128'(push_total_o), 128'(0));
    chk({tag, ":high_water"}, 128'(high_water_o), 128'(0));
`endif
  endtask

  // Drive one clock cycle of stimulus (called #1 after a posedge), advance the
  // model by the FIFO rules, then check outputs #1 after the next posedge.
  task automatic step(input string tag, input logic we, input logic [ENTRY_W-1:0] d,
                      input logic rdy);
    bit do_pop, do_push;
    fifo_write_en_i = we;
    fifo_data_i     = d;
    req_ready_i     = rdy;
    do_pop  = (m_q.size() != 0) && rdy;
    do_push = we && ((m_q.size() < DEPTH) || do_pop);
    @(posedge clk);
    #1;
    if (do_pop)  void'(m_q.pop_front());
    if (do_push) begin
      m_q.push_back(d);
      if (m_total != 64'hFFFF_FFFF) m_total++;
    end
    if (we && !do_push) m_ovf = 1'b1;
    if (m_q.size() > m_hw) m_hw = m_q.size();
    fifo_write_en_i = 1'b0;
    req_ready_i     = 1'b0;
    check_state(tag);
  endtask

  function automatic logic [ENTRY_W-1:0] rnd_entry();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[ENTRY_W-1:0];
  endfunction

  initial begin
    logic [ENTRY_W-1:0] e;
    logic [ENTRY_W-1:0] special;
    logic [ENTRY_W-1:0] last_new;

    rst             = 1'b1;
    fifo_write_en_i = 1'b0;
    fifo_data_i     = '0;
    req_ready_i     = 1'b0;
    model_reset();
    #2;
    check_state("reset_por");
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check_state("post_reset_idle");

    // 1: async reset mid-traffic with five entries
    for (int i = 0; i < 5; i++) step("fill5", 1'b1, rnd_entry(), 1'b0);
    chk("fill5:count5", 128'(count_o), 128'(5));
    rst = 1'b1;
    #1;
    model_reset();
    check_state("async_reset");
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check_state("after_reset_release");

    // 2: single push into empty, held while ready=0
    special = {1'b1, 16'h00A5, 64'h1000};
    step("push_special", 1'b1, special, 1'b0);
    chk("special_head", 128'(req_data_o), 128'(special));
    for (int i = 0; i < 10; i++) step("hold", 1'b0, '0, 1'b0);

    // 3: almost-full threshold
    for (int i = 0; i < 13; i++) step("fill14", 1'b1, rnd_entry(), 1'b0);
    chk("afull_at14", 128'(fifo_afull_o), 128'(1));
    step("pop_to13", 1'b0, '0, 1'b1);
    chk("afull_at13", 128'(fifo_afull_o), 128'(0));

    // 4: fill to full, then an overflowing push is dropped
    for (int i = 0; i < 3; i++) step("fill16", 1'b1, rnd_entry(), 1'b0);
    e = req_data_o;
    step("ovf_push", 1'b1, rnd_entry(), 1'b0);
    chk("ovf_count16", 128'(count_o), 128'(16));
    chk("ovf_head_unchanged", 128'(req_data_o), 128'(e));

    // 5: full with simultaneous push and pop, new entry leaves on 16th pop
    last_new = rnd_entry();
    step("full_push_pop", 1'b1, last_new, 1'b1);
    chk("full_pp_count16", 128'(count_o), 128'(16));
    for (int i = 0; i < 15; i++) step("drain", 1'b0, '0, 1'b1);
    chk("sixteenth_head", 128'(req_data_o), 128'(last_new));
    step("drain_last", 1'b0, '0, 1'b1);
    chk("empty_after_drain", 128'(req_valid_o), 128'(0));

    // 6: random traffic; pointers start mid-array so the wrap is crossed
    for (int i = 0; i < 40; i++) begin
      step("random", ($urandom_range(0, 9) < 6), rnd_entry(), $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < DEPTH + 2; i++) step("final_drain", 1'b0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
